riscv_dmem_responder: RTL

- Data-memory responder: the target side of the core's load/store request/response handshake. The core is the initiator.
- Accepts one request at a time and performs a byte-lane-masked write or a full-word read on an internal word array.
- Returns the response after a configurable number of wait states.
- Sits between the riscv_datapath memory port and the storage; also used stand-alone in benches to model slow memory.

---
 rtl/riscv_mem_pkg.sv | 21 ++
 rtl/riscv_dmem_array.sv | 34 +++
 rtl/riscv_dmem_responder.sv | 103 ++++++++++
 3 files changed

// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - shared types and constants for the data-memory responder
package riscv_mem_pkg;

    localparam int BYTE_LANES    = 4;
    localparam int WORD_ADDR_LSB = 2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        COMMIT,
        RESP
    } dmem_state_e;

    typedef struct packed {
        logic                  we;
        logic [31:0]           addr;
        logic [31:0]           wdata;
        logic [BYTE_LANES-1:0] be;
    } dmem_req_t;

endpackage

// File: rtl/riscv_dmem_array.sv
// rtl/riscv_dmem_array.sv - single-port word array with byte write enables and synchronous read
module riscv_dmem_array
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 8192,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [BYTE_LANES-1:0] be,
    input  logic [AW-1:0]         addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    // Contents are deliberately not reset so they survive a controller reset.
    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < BYTE_LANES; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/riscv_dmem_responder.sv
// rtl/riscv_dmem_responder.sv - load/store target with configurable wait states
module riscv_dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 8192,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        a_rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT    = 33'(DEPTH_WORDS * 4);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    dmem_state_e state;
    dmem_req_t   req_q;
    logic [3:0]  cnt;
    logic        rd_ok;
    logic [31:0] arr_rdata;
    logic [31:0] offset;
    logic        acc_err;
    logic [AW-1:0] idx;

    // Subtraction wraps, so addresses below BASE_ADDR land in the out-of-range check.
    assign offset  = req_q.addr - BASE_ADDR;
    assign acc_err = (offset[WORD_ADDR_LSB-1:0] != '0) || ({1'b0, offset} >= LIMIT);
    assign idx     = offset[WORD_ADDR_LSB +: AW];

    // The array read register is only observed for error-free loads.
    assign resp_rdata = rd_ok ? arr_rdata : 32'h0;

    riscv_dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk  (clk),
        .en   ((state == COMMIT) && !acc_err),
        .we   (req_q.we),
        .be   (req_q.be),
        .addr (idx),
        .wdata(req_q.wdata),
        .rdata(arr_rdata)
    );

    always_ff @(posedge clk or negedge a_rstn) begin
        if (!a_rstn) begin
            state      <= IDLE;
            req_q      <= '0;
            cnt        <= 4'd0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            rd_ok      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_q     <= '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};
                        cnt       <= CNT_INIT;
                        req_ready <= 1'b0;
                        state     <= (LATENCY == 1) ? COMMIT : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    resp_valid <= 1'b1;
                    resp_err   <= acc_err;
                    rd_ok      <= !acc_err && !req_q.we;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        rd_ok      <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
